// File: rtl/ram_3_sync_if.sv
// ram_3_sync_if: access bus for the ram_3_sync storage block.
//   data_in  : write data                   (master -> slave)
//   address  : word address                 (master -> slave)
//   write    : 1 = write, 0 = read          (master -> slave)
//   select   : chip select                  (master -> slave)
//   data_out : registered read data         (slave -> master)
//   busy     : clear sweep in progress      (slave -> master)
interface ram_3_sync_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              select;
  logic [DATA_W-1:0] data_out;
  logic              busy;

  modport master (
    output data_in, address, write, select,
    input  data_out, busy
  );

  modport slave (
    input  data_in, address, write, select,
    output data_out, busy
  );
endinterface

// File: rtl/ram_3_sync.sv
// ram_3_sync: single-port synchronous RAM (2**ADDR_W x DATA_W) with
// chip select, write enable, registered read and a hardware clear sweep
// that zeroes every word after reset.
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset; starts the clear sweep
//   bus : ram_3_sync_if slave (data_in, address, write, select in;
//         data_out, busy out)
module ram_3_sync #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_3_sync_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W-1:0] data_out_reg;

  logic              ptr_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign ptr_last = (ptr_reg == {ADDR_W{1'b1}});

  // Next-state logic for the clear sweep.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (state_reg == CLEAR) begin
      ptr_next = ptr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (ptr_last) begin
        state_next = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // The sweep and user writes share the single write port; user accesses
  // are locked out while clearing, so the sweep simply owns the port then.
  // Nothing is written on a reset edge: the sweep that follows zeroes all.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    mem_wdata = bus.data_in;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_reg;
        mem_wdata = '0;
      end else begin
        mem_we = bus.select && bus.write;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port. Deselected or busy forces zero; a write cycle
  // leaves the previous read data in place (no write-through).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_reg <= '0;
    end else if (state_reg == CLEAR) begin
      data_out_reg <= '0;
    end else if (!bus.select) begin
      data_out_reg <= '0;
    end else if (!bus.write) begin
      data_out_reg <= mem[bus.address];
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.busy     = (state_reg == CLEAR);

endmodule

// File: tb/tb_ram_3_sync.sv
// tb_ram_3_sync: directed test of ram_3_sync against a behavioural model
// (plain array plus a sweep countdown), checked every cycle on the falling
// edge, plus literal expectations for the named scenarios.
module tb_ram_3_sync;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;

  logic clk;
  logic rst;

  ram_3_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_3_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [7:0] model_mem [DEPTH];
  int         sweep_left  = 0;
  logic [7:0] exp_dout    = 8'h00;
  logic       exp_busy    = 1'b0;
  logic       model_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances on the same rising edge.
  task automatic cycle(input logic r, input logic s, input logic w,
                       input logic [9:0] a, input logic [7:0] d);
    rst         = r;
    bus.select  = s;
    bus.write   = w;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      sweep_left  = DEPTH;
      exp_dout    = 8'h00;
      model_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    end else if (sweep_left > 0) begin
      sweep_left--;
      exp_dout = 8'h00;
    end else if (!s) begin
      exp_dout = 8'h00;
    end else if (w) begin
      model_mem[a] = d;
    end else begin
      exp_dout = model_mem[a];
    end
    exp_busy = (sweep_left > 0);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 10'd0, 8'h00);
  endtask

  task automatic rd(input logic [9:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d);
  endtask

  // Counts idle cycles until busy drops, bounded.
  task automatic wait_sweep(output int n);
    n = 0;
    while (bus.busy && n < 3000) begin
      idle();
      n++;
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy", int'(bus.busy), int'(exp_busy));
      check("data_out", int'(bus.data_out), int'(exp_dout));
    end
  end

  initial begin
    int n;
    int a;
    rst         = 1'b0;
    bus.select  = 1'b0;
    bus.write   = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("phase: reset and first sweep");
    cycle(1'b1, 1'b0, 1'b0, 10'd0, 8'h00);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_dout", int'(bus.data_out), 0);
    cycle(1'b0, 1'b1, 1'b1, 10'd10, 8'hFF);     // ignored write while busy
    check("busy_dout_zero", int'(bus.data_out), 0);
    wait_sweep(n);
    check("sweep_len", n + 1, 1024);
    rd(10'd0);    check("rd0_clear", int'(bus.data_out), 8'h00);
    rd(10'd511);  check("rd511_clear", int'(bus.data_out), 8'h00);
    rd(10'd1023); check("rd1023_clear", int'(bus.data_out), 8'h00);
    rd(10'd10);   check("busy_write_ignored", int'(bus.data_out), 8'h00);

    $display("phase: reset mid-sweep");
    cycle(1'b1, 1'b0, 1'b0, 10'd0, 8'h00);
    repeat (500) idle();
    check("mid_busy", int'(bus.busy), 1);
    cycle(1'b1, 1'b0, 1'b0, 10'd0, 8'h00);
    wait_sweep(n);
    check("restart_sweep_len", n, 1024);

    $display("phase: fill and random reads");
    for (int k = 0; k < DEPTH; k++) wr(10'(k), 8'((2 * k) % 256));
    for (int i = 0; i < DEPTH; i++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      rd(10'(a));
      check("rand_rd", int'(bus.data_out), (2 * a) % 256);
    end
    rd(10'd200);  check("rd200", int'(bus.data_out), 8'h90);
    rd(10'd1023); check("rd1023", int'(bus.data_out), 8'hFE);

    $display("phase: back-to-back access");
    wr(10'd5, 8'hA5); check("wr_hold", int'(bus.data_out), 8'hFE);
    rd(10'd5);        check("raw_5", int'(bus.data_out), 8'hA5);
    wr(10'd7, 8'h3C);
    wr(10'd7, 8'hC3);
    rd(10'd7);        check("last_wins_7", int'(bus.data_out), 8'hC3);

    $display("phase: deselect");
    cycle(1'b0, 1'b0, 1'b1, 10'd3, 8'h77);
    check("desel_dout", int'(bus.data_out), 8'h00);
    rd(10'd3);        check("desel_no_write", int'(bus.data_out), 8'h06);
    idle();           check("desel_zero", int'(bus.data_out), 8'h00);

    $display("phase: reset after load");
    cycle(1'b1, 1'b0, 1'b0, 10'd0, 8'h00);
    wait_sweep(n);
    check("reload_sweep_len", n, 1024);
    rd(10'd5);    check("clr_5", int'(bus.data_out), 8'h00);
    rd(10'd7);    check("clr_7", int'(bus.data_out), 8'h00);
    rd(10'd200);  check("clr_200", int'(bus.data_out), 8'h00);
    rd(10'd1023); check("clr_1023", int'(bus.data_out), 8'h00);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_3_sync.md
Name: ram_3_sync

Overview:
- Single-port synchronous RAM, 1024 words x 8 bits, with chip-select and write-enable; the storage block for the lab datapath.
- Reset triggers a hardware clear sweep that zeroes every location; a busy flag is high while the sweep runs.
- Reads are registered (1-cycle latency).

Parameters:
ADDR_W, 10, address width; depth = 2**ADDR_W words
DATA_W, 8, word width in bits

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
data_out  output  DATA_W  registered read data
data_in  input  DATA_W  write data
address  input  ADDR_W  word address
write  input  1  1 = write, 0 = read (qualified by select)
select  input  1  chip select; no access when 0
busy  output  1  high while the clear sweep runs; accesses are ignored

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - data_out <= 0, busy <= 1.
  - Internal clear pointer <= 0.
  - Clear-state FSM enters CLEAR.
- FSM states are CLEAR and READY.
  - CLEAR:
    - Each cycle writes 0 to mem[ptr], then ptr <= ptr+1.
    - After writing location 2**ADDR_W-1, go to READY and busy <= 0.
    - The sweep takes exactly 1024 cycles after rst deasserts.
  - READY: normal access.
- rst asserted during CLEAR restarts the sweep at address 0. rst asserted in READY re-enters CLEAR and all contents become 0.
- While busy=1:
  - write and select are ignored; no user write takes effect.
  - data_out is held at 0.
- READY, select=1, write=1:
  - mem[address] <= data_in at the rising edge.
  - data_out holds its previous value; no write-through.
- READY, select=1, write=0: data_out <= mem[address] at the rising edge. Valid one cycle after address is presented.
- Back-to-back access:
  - A read of an address written in the previous cycle returns the new data.
  - Writes to the same address in consecutive cycles: the last write wins.
- READY, select=0:
  - No memory change.
  - data_out <= 0 (deselected output is zero, not high-Z).
- Addresses are exactly ADDR_W bits, so no out-of-range condition exists. Address 1023 and address 0 behave identically to others.
- data_in is stored unmodified at full DATA_W bits; no arithmetic inside the block.
- Memory content is undefined only before the first reset. After any completed sweep every word reads 0.
- The implementation must infer block RAM: single write port plus a registered read.

Test Plan:
- Reset, then hold rst=0 -> busy=1 for exactly 1024 cycles, then busy=0. Reading addresses 0, 511 and 1023 returns 0x00.
- Fill all 1024 addresses with data_in=(2*k)%256 (select=1, write=1). Then read 1024 pseudo-random addresses with write=0 -> each data_out equals (2*address)%256 one cycle later (e.g. addr 200 -> 0x90, addr 1023 -> 0xFE).
- Write 0xA5 to addr 5, then read addr 5 on the next cycle -> data_out=0xA5. Write 0x3C then 0xC3 to addr 7 in consecutive cycles, then read -> 0xC3.
- Attempt a write during busy (addr 10, 0xFF), then finish the sweep and read addr 10 -> 0x00. Assert rst mid-sweep (cycle 500) -> busy stays high another full 1024 cycles from release.
- select=0 with write=1 (addr 3, 0x77), then read addr 3 -> previous content unchanged. While select=0 -> data_out=0.
- After data is loaded, assert rst for 1 cycle and wait for the sweep -> all previously written addresses read 0x00.
